// File: rtl/vga_random_pixel.sv
// Random-tile pixel stage behind a VGA sync generator: one LFSR colour per
// tile, each line of a tile row replayed from a saved seed, sync delayed 1 clk.
module vga_random_pixel #(
    parameter int          TILE_SHIFT = 3,
    parameter int          COLOR_BITS = 3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  display_on,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  animate,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] rgb,
    output logic [7:0]            frame_count
);

    // An all-zero LFSR state would lock up, so a zero seed is remapped.
    localparam logic [15:0]           SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [TILE_SHIFT-1:0] TILE_LAST = '1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] lfsr;
    logic [15:0] row_seed;
    logic [15:0] frame_seed;
    logic [15:0] cur;
    logic        frame_start;
    logic        line_start;
    logic        new_row;
    logic        tile_end;

    always_comb begin
        frame_start = (hpos == 10'd0) && (vpos == 10'd0);
        line_start  = (hpos == 10'd0);
        new_row     = line_start && (vpos[TILE_SHIFT-1:0] == '0);
        tile_end    = display_on && (hpos[TILE_SHIFT-1:0] == TILE_LAST);
        // NOTE: the if/else chain ends in a plain else, so cur is assigned on every path and no latch is inferred.
        if (frame_start)     cur = frame_seed;
        else if (new_row)    cur = lfsr;
        else if (line_start) cur = row_seed;
        else                 cur = lfsr;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            rgb         <= '0;
            frame_count <= 8'd0;
            lfsr        <= SEED_INIT;
            row_seed    <= SEED_INIT;
            frame_seed  <= SEED_INIT;
        end else begin
            hsync <= hsync_in;
            vsync <= vsync_in;
            rgb   <= display_on ? cur[COLOR_BITS-1:0] : '0;
            lfsr  <= tile_end ? lfsr_next(cur) : cur;
            if (new_row)
                row_seed <= cur;
            if (frame_start) begin
                frame_count <= frame_count + 8'd1;
                if (animate)
                    frame_seed <= lfsr_next(frame_seed);
            end
        end
    end

endmodule

// File: tb/tb_vga_random_pixel.sv
// Randomized bench for vga_random_pixel on a reduced raster; expected colours
// come from step counts into the LFSR sequence rather than a register model.
module tb_vga_random_pixel;

    localparam int          H_DISPLAY = 76;   // last tile column only half visible
    localparam int          H_TOTAL   = 100;
    localparam int          V_DISPLAY = 28;   // last tile row only half visible
    localparam int          V_TOTAL   = 40;
    localparam int          TS        = 3;
    localparam int          CB        = 3;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          STEPS_PER_LINE = H_DISPLAY >> TS;

    logic          clk = 1'b0;
    logic          reset;
    logic          hsync_in;
    logic          vsync_in;
    logic          display_on;
    logic [9:0]    hpos;
    logic [9:0]    vpos;
    logic          animate;
    logic          hsync;
    logic          vsync;
    logic [CB-1:0] rgb;
    logic [7:0]    frame_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_frame_seed;
    logic [15:0] m_next_seed;
    logic [7:0]  m_count;
    logic        m_known;

    vga_random_pixel #(.TILE_SHIFT(TS), .COLOR_BITS(CB), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .animate(animate),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Colour of a visible pixel = frame seed advanced once per completed visible
    // tile: full tile rows above it, plus tiles to its left on its own line.
    function automatic logic [15:0] color_at(input logic [15:0] seed, input int x, input int y);
        logic [15:0] s = seed;
        int n = (y >> TS) * STEPS_PER_LINE + (x >> TS);
        for (int i = 0; i < n; i++) s = lfsr_next(s);
        return s & 16'((1 << CB) - 1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int x, input int y, input logic rst);
        logic [15:0] e_rgb;
        logic        e_hs;
        logic        e_vs;
        logic        chk_rgb;
        reset      = rst;
        hpos       = 10'(x);
        vpos       = 10'(y);
        display_on = (x < H_DISPLAY) && (y < V_DISPLAY);
        hsync_in   = 1'($urandom);
        vsync_in   = 1'($urandom);
        if (rst) begin
            m_count     = 8'd0;
            m_next_seed = SEED;
            m_known     = 1'b0;
        end else if (x == 0 && y == 0) begin
            m_frame_seed = m_next_seed;
            if (animate) m_next_seed = lfsr_next(m_next_seed);
            m_count = m_count + 8'd1;
            m_known = 1'b1;
        end
        e_hs    = rst ? 1'b0 : hsync_in;
        e_vs    = rst ? 1'b0 : vsync_in;
        chk_rgb = rst || !display_on || m_known;
        e_rgb   = (rst || !display_on) ? 16'h0000 : color_at(m_frame_seed, x, y);
        @(posedge clk);
        #1;
        check("hsync", 16'(hsync), 16'(e_hs));
        check("vsync", 16'(vsync), 16'(e_vs));
        if (chk_rgb) check("rgb", 16'(rgb), e_rgb);
        check("frame_count", 16'(frame_count), 16'(m_count));
    endtask

    // animate is re-randomized every line; only its value at (0,0) matters.
    task automatic run_frame(input logic anim0, input int frame_no, input int reset_line);
        for (int y = 0; y < V_TOTAL; y++) begin
            for (int x = 0; x < H_TOTAL; x++) begin
                if (x == 0) animate = (y == 0) ? anim0 : 1'($urandom);
                step(x, y, (y == reset_line) && (x == 10 || x == 11));
                if (frame_no == 1 && y == 0 && x == 0) check("first_pixel", 16'(rgb), 16'h0001);
                if (frame_no == 1 && y == 0 && x == 8) check("second_tile", 16'(rgb), 16'h0000);
                if (frame_no == 4 && y == 0 && x == 0) check("animated_seed", 16'(rgb), 16'hE270 & 16'h0007);
                if (frame_no == 6 && y == 0 && x == 0) check("count_after_reset", 16'(frame_count), 16'h0001);
            end
        end
    endtask

    initial begin
        m_frame_seed = SEED;
        m_next_seed  = SEED;
        m_count      = 8'd0;
        m_known      = 1'b0;
        animate      = 1'($urandom);
        for (int i = 0; i < 3; i++)
            step(int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(0, V_TOTAL - 1)), 1'b1);
        run_frame(1'b0, 1, -1);
        run_frame(1'b0, 2, -1);
        run_frame(1'b1, 3, -1);
        run_frame(1'($urandom), 4, -1);
        run_frame(1'($urandom), 5, int'($urandom_range(1, V_DISPLAY - 1)));
        run_frame(1'($urandom), 6, -1);
        run_frame(1'($urandom), 7, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
